// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end.
// Keeps a fetch PC and issues at most one instruction-memory request at a time.
// Fetched words go into a 2-entry {pc, instr} FIFO that feeds the decoder.
// A redirect from execute flushes the FIFO, reloads the PC and drops any
// response still in flight.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   redirect_valid, redirect_pc      taken branch/jump target from execute
//   imem_req_valid/ready/addr        request channel to instruction memory
//   imem_resp_valid/data             response channel from instruction memory
//   instr_valid/instr/instr_pc       FIFO head presented to the decoder
//   instr_ready                      decoder consumes the head this cycle
//
// state   | meaning
// S_REQ   | nothing outstanding, may issue a request
// S_WAIT  | request outstanding, response will be pushed to the FIFO
// S_DISCD | request outstanding, response will be dropped (stale after redirect)
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DISCD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] issued_pc_q, issued_pc_d;
  logic [31:0] e0_pc_q, e0_pc_d, e0_ins_q, e0_ins_d;
  logic [31:0] e1_pc_q, e1_pc_d, e1_ins_q, e1_ins_d;
  logic [1:0]  count_q, count_d;

  logic        outstanding;
  logic [1:0]  occupancy;
  logic        req_hs;
  logic        push;
  logic        pop;

  assign outstanding = (state_q != S_REQ);
  assign occupancy   = count_q + {1'b0, outstanding};

  // Outputs are forced low while reset is held so the first reset cycle is
  // clean even before the flops have been cleared.
  assign imem_req_valid = !reset && (state_q == S_REQ) && (occupancy < 2'd2);
  assign imem_req_addr  = pc_q;
  assign instr_valid    = !reset && (count_q != 2'd0);
  assign instr          = reset ? 32'h0 : e0_ins_q;
  assign instr_pc       = reset ? 32'h0 : e0_pc_q;

  assign req_hs = imem_req_valid && imem_req_ready;
  // A response landing in the redirect cycle belongs to the old path.
  assign push   = (state_q == S_WAIT) && imem_resp_valid && !redirect_valid;
  assign pop    = instr_valid && instr_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    issued_pc_d = issued_pc_q;
    e0_pc_d     = e0_pc_q;
    e0_ins_d    = e0_ins_q;
    e1_pc_d     = e1_pc_q;
    e1_ins_d    = e1_ins_q;
    count_d     = count_q;

    if (req_hs) begin
      pc_d        = pc_q + 32'd4;
      issued_pc_d = pc_q;
    end
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end

    unique case (state_q)
      S_REQ: begin
        if (req_hs) state_d = redirect_valid ? S_DISCD : S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid)     state_d = S_REQ;
        else if (redirect_valid) state_d = S_DISCD;
      end
      S_DISCD: begin
        if (imem_resp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (redirect_valid) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            e0_pc_d  = issued_pc_q;
            e0_ins_d = imem_resp_data;
          end else begin
            e1_pc_d  = issued_pc_q;
            e1_ins_d = imem_resp_data;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          e0_pc_d  = e1_pc_q;
          e0_ins_d = e1_ins_q;
          count_d  = count_q - 2'd1;
        end
        2'b11: begin
          // Head leaves, new word lands behind whatever remains.
          if (count_q == 2'd1) begin
            e0_pc_d  = issued_pc_q;
            e0_ins_d = imem_resp_data;
          end else begin
            e0_pc_d  = e1_pc_q;
            e0_ins_d = e1_ins_q;
            e1_pc_d  = issued_pc_q;
            e1_ins_d = imem_resp_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_REQ;
      pc_q        <= {RESET_PC[31:2], 2'b00};
      issued_pc_q <= 32'h0;
      e0_pc_q     <= 32'h0;
      e0_ins_q    <= 32'h0;
      e1_pc_q     <= 32'h0;
      e1_ins_q    <= 32'h0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      issued_pc_q <= issued_pc_d;
      e0_pc_q     <= e0_pc_d;
      e0_ins_q    <= e0_ins_d;
      e1_pc_q     <= e1_pc_d;
      e1_ins_q    <= e1_ins_d;
      count_q     <= count_d;
    end
  end

endmodule
